// File: rtl/adder_pkg.sv
// Shared definitions for the adder set: sequencer state encoding and default operand width.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder; the only arithmetic cell of the serial adder.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per clock,
// through a start/busy/done handshake with a registered sum and carry-out.
module serial_adder
  import adder_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           r_state;
  state_e           w_next_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             w_s;
  logic             w_c;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_next;

  fa_cell u_fa (
    .x (r_a_sr[0]),
    .y (r_b_sr[0]),
    .ci(r_carry),
    .s (w_s),
    .co(w_c)
  );

  // A new request is taken in IDLE and also in DONE, which gives back-to-back operation.
  assign w_accept   = start && (r_state == IDLE || r_state == DONE);
  assign w_last     = (r_state == RUN) && (r_cnt == LAST_CNT);
  assign w_sum_next = {w_s, {(WIDTH-1){1'b0}}} | (r_sum_sr >> 1);

  // NOTE: next-state logic assigns its default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next_state = RUN;
      RUN:     if (w_last) w_next_state = DONE;
      DONE:    w_next_state = start ? RUN : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every datapath register is cleared by reset, so an aborted addition leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a_sr  <= a;
      r_b_sr  <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_sum_sr <= w_sum_next;
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_carry  <= w_c;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_sum  <= w_sum_next;
        r_cout <= w_c;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
